// File: rtl/dmem_axi_queue_unit.sv
// Data-memory access unit: in-order request queue driving one AXI4-Lite transaction at a time.
// Optional macro DMEM_MISALIGN_CHECK_EN: misaligned head entries complete with an error and no bus traffic.
module dmem_axi_queue_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int QDEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_req,
  input  logic                mem_wr,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  output logic                mem_gnt,
  output logic                mem_ready,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_error,
  output logic                mem_idle,
  output logic [ADDR_W-1:0]   M_AXI_AWADDR,
  output logic [2:0]          M_AXI_AWPROT,
  output logic                M_AXI_AWVALID,
  input  logic                M_AXI_AWREADY,
  output logic [DATA_W-1:0]   M_AXI_WDATA,
  output logic [DATA_W/8-1:0] M_AXI_WSTRB,
  output logic                M_AXI_WVALID,
  input  logic                M_AXI_WREADY,
  input  logic [1:0]          M_AXI_BRESP,
  input  logic                M_AXI_BVALID,
  output logic                M_AXI_BREADY,
  output logic [ADDR_W-1:0]   M_AXI_ARADDR,
  output logic [2:0]          M_AXI_ARPROT,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  input  logic [DATA_W-1:0]   M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY
);
  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(QDEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WRESP, RDATA} state_t;

  logic              q_wr    [QDEPTH];
  logic [ADDR_W-1:0] q_addr  [QDEPTH];
  logic [DATA_W-1:0] q_wdata [QDEPTH];
  logic [STRB_W-1:0] q_wstrb [QDEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  state_t           state, state_nx;
  logic             aw_pend, w_pend;
  logic             enq, deq, b_hs, r_hs, misalign_done;
  logic             h_wr, h_misalign, b_err, r_err, r_okay;
  logic [ADDR_W-1:0] h_addr;

  assign h_wr   = q_wr[head];
  assign h_addr = q_addr[head];
  assign b_err  = M_AXI_BRESP inside {2'b10, 2'b11};
  assign r_err  = M_AXI_RRESP inside {2'b10, 2'b11};
  assign r_okay = (M_AXI_RRESP == 2'b00);

`ifdef DMEM_MISALIGN_CHECK_EN
  localparam int OFF_W = $clog2(STRB_W);
  assign h_misalign = (h_addr[OFF_W-1:0] != '0);
`else
  assign h_misalign = 1'b0;
`endif

  assign mem_gnt  = (count < CNT_W'(QDEPTH));
  assign mem_idle = (count == '0) && (state == IDLE);
  assign enq      = mem_req && mem_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (count != '0) state_nx = h_misalign ? IDLE : ISSUE;
      ISSUE:   if (h_wr) begin
                 if ((!aw_pend || M_AXI_AWREADY) && (!w_pend || M_AXI_WREADY)) state_nx = WRESP;
               end else if (M_AXI_ARREADY) begin
                 state_nx = RDATA;
               end
      WRESP:   if (M_AXI_BVALID) state_nx = IDLE;
      RDATA:   if (M_AXI_RVALID) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    M_AXI_AWPROT  = 3'b000;
    M_AXI_ARPROT  = 3'b000;
    M_AXI_AWADDR  = h_addr;
    M_AXI_ARADDR  = h_addr;
    M_AXI_WDATA   = q_wdata[head];
    M_AXI_WSTRB   = q_wstrb[head];
    M_AXI_AWVALID = (state == ISSUE) && aw_pend;
    M_AXI_WVALID  = (state == ISSUE) && w_pend;
    M_AXI_ARVALID = (state == ISSUE) && !h_wr;
    M_AXI_BREADY  = (state == WRESP);
    M_AXI_RREADY  = (state == RDATA);
    b_hs          = M_AXI_BREADY && M_AXI_BVALID;
    r_hs          = M_AXI_RREADY && M_AXI_RVALID;
    misalign_done = (state == IDLE) && (count != '0) && h_misalign;
    deq           = b_hs || r_hs || misalign_done;
  end

  // AW and W complete independently; each pending flag clears on its own handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_pend <= 1'b0;
      w_pend  <= 1'b0;
    end else if (state == IDLE && state_nx == ISSUE) begin
      aw_pend <= h_wr;
      w_pend  <= h_wr;
    end else if (state == ISSUE) begin
      if (M_AXI_AWREADY) aw_pend <= 1'b0;
      if (M_AXI_WREADY)  w_pend  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_wr[tail]    <= mem_wr;
      q_addr[tail]  <= mem_addr;
      q_wdata[tail] <= mem_wdata;
      q_wstrb[tail] <= mem_wstrb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready <= 1'b0;
      mem_error <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_ready <= deq;
      mem_error <= (b_hs && b_err) || (r_hs && r_err) || misalign_done;
      if (r_hs && r_okay) mem_rdata <= M_AXI_RDATA;
    end
  end
endmodule

// File: tb/tb_dmem_axi_queue_unit.sv
// Randomised bench for dmem_axi_queue_unit: a transaction-level queue model and AXI slave checked every cycle.
`timescale 1ns/1ps
module tb_dmem_axi_queue_unit;
  localparam int ADDR_W = 32, DATA_W = 32, QDEPTH = 4, STRB_W = DATA_W / 8;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic mem_req, mem_wr, mem_gnt, mem_ready, mem_error, mem_idle;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [DATA_W-1:0] wdata, rdata;
  logic [STRB_W-1:0] wstrb;
  logic [1:0] bresp, rresp;

  dmem_axi_queue_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .mem_error(mem_error), .mem_idle(mem_idle),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } req_t;

  req_t stim_q[$];
  req_t reqq[$];

  int tests = 0, fails = 0, cyc = 0;
  bit issued, aw_got, w_got, ar_got, exp_ready, exp_err, hold;
  logic [DATA_W-1:0] exp_rdata;
  bit bvalid_r, rvalid_r, b_wait, r_wait;
  logic [1:0] bresp_r, rresp_r;
  logic [DATA_W-1:0] rdata_r;
  int b_cnt, r_cnt, aw_late_cnt;
  int p_ready, gap_pct, dly_min, dly_max, aw_late;
  bit aw_hold, ar_hold, force_resp, spurious;
  logic [1:0] f_bresp, f_rresp;
  logic [DATA_W-1:0] f_rdata;
  int b_count, ready_count, acc_edge, ready_edge, w_only, ar_seen;
  logic last_err;
  logic [ADDR_W-1:0] last_awaddr;
  logic [DATA_W-1:0] last_wdata;
  logic [STRB_W-1:0] last_wstrb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] pick_resp();
    return ($urandom_range(9) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
  endfunction

  task automatic model_reset();
    stim_q.delete(); reqq.delete();
    issued = 0; aw_got = 0; w_got = 0; ar_got = 0; exp_ready = 0; exp_err = 0; hold = 0;
    exp_rdata = '0; bvalid_r = 0; rvalid_r = 0; b_wait = 0; r_wait = 0; aw_late_cnt = 0;
  endtask

  // One clock: check outputs after the last edge, drive inputs, advance the model across the next edge
  task automatic step();
    req_t h;
    bit e_awv, e_wv, e_arv, e_br, e_rr, acc, aw_hs, w_hs, ar_hs, b_hs, r_hs, done;
    @(negedge clk);
    cyc++;
    h = (reqq.size() > 0) ? reqq[0] : '0;
    e_awv = issued && h.wr && !aw_got;
    e_wv  = issued && h.wr && !w_got;
    e_arv = issued && !h.wr && !ar_got;
    e_br  = issued && h.wr && aw_got && w_got;
    e_rr  = issued && !h.wr && ar_got;

    check("mem_ready", mem_ready, exp_ready);
    if (exp_ready) check("mem_error", mem_error, exp_err);
    check("mem_rdata", mem_rdata, exp_rdata);
    check("mem_gnt", mem_gnt, reqq.size() < QDEPTH);
    check("mem_idle", mem_idle, reqq.size() == 0);
    check("awvalid", awvalid, e_awv);
    check("wvalid", wvalid, e_wv);
    check("arvalid", arvalid, e_arv);
    check("bready", bready, e_br);
    check("rready", rready, e_rr);
    check("prot", {awprot, arprot}, 6'b0);
    if (e_awv) check("awaddr", awaddr, h.addr);
    if (e_wv)  check("wdata", {wstrb, wdata}, {h.wstrb, h.wdata});
    if (e_arv) check("araddr", araddr, h.addr);
    if (mem_ready) begin ready_count++; ready_edge = cyc - 1; last_err = mem_error; end
    if (awvalid && !wvalid) w_only++;
    if (arvalid) ar_seen++;

    if (!rst_n) mem_req = 0;
    else if (!hold) begin
      if (stim_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
        mem_req = 1;
        {mem_wr, mem_addr, mem_wdata, mem_wstrb} = stim_q[0];
      end else begin
        mem_req = 0; mem_wr = 1'($urandom); mem_addr = $urandom; mem_wdata = $urandom;
        mem_wstrb = 4'($urandom);
      end
    end
    awready = !aw_hold && (aw_late_cnt == 0) && ($urandom_range(99) < p_ready);
    if (e_awv && aw_late_cnt > 0) aw_late_cnt--;
    wready  = ($urandom_range(99) < p_ready);
    arready = !ar_hold && ($urandom_range(99) < p_ready);
    if (b_wait && !bvalid_r) begin
      if (b_cnt == 0) begin bvalid_r = 1; bresp_r = force_resp ? f_bresp : pick_resp(); end
      else b_cnt--;
    end
    if (r_wait && !rvalid_r) begin
      if (r_cnt == 0) begin
        rvalid_r = 1; rresp_r = force_resp ? f_rresp : pick_resp();
        rdata_r = force_resp ? f_rdata : $urandom;
      end else r_cnt--;
    end
    bvalid = bvalid_r || spurious; bresp = bvalid_r ? bresp_r : 2'($urandom);
    rvalid = rvalid_r || spurious; rresp = rvalid_r ? rresp_r : 2'($urandom);
    rdata  = rvalid_r ? rdata_r : $urandom;

    exp_ready = 0; exp_err = 0;
    if (!rst_n) return;
    aw_hs = e_awv && awready; w_hs = e_wv && wready; ar_hs = e_arv && arready;
    b_hs = e_br && bvalid_r; r_hs = e_rr && rvalid_r;
    acc = mem_req && (reqq.size() < QDEPTH);
    done = 0;
    if (aw_hs) begin aw_got = 1; last_awaddr = awaddr; end
    if (w_hs) begin w_got = 1; last_wdata = wdata; last_wstrb = wstrb; end
    if ((aw_hs || w_hs) && aw_got && w_got) begin b_wait = 1; b_cnt = $urandom_range(dly_max, dly_min); end
    if (ar_hs) begin ar_got = 1; r_wait = 1; r_cnt = $urandom_range(dly_max, dly_min); end
    if (b_hs) begin
      b_count++; done = 1; exp_err = bresp_r[1]; bvalid_r = 0; b_wait = 0;
    end
    if (r_hs) begin
      done = 1; exp_err = rresp_r[1]; rvalid_r = 0; r_wait = 0;
      if (rresp_r == 2'b00) exp_rdata = rdata_r;
    end
    if (done) begin
      exp_ready = 1; void'(reqq.pop_front()); issued = 0; aw_got = 0; w_got = 0; ar_got = 0;
    end else if (!issued && reqq.size() > 0) begin
`ifdef DMEM_MISALIGN_CHECK_EN
      if (h.addr[1:0] != 2'b00) begin
        exp_ready = 1; exp_err = 1; void'(reqq.pop_front());
      end else
`endif
      begin
        issued = 1;
        if (h.wr) aw_late_cnt = aw_late;
      end
    end
    if (acc) begin reqq.push_back(stim_q.pop_front()); acc_edge = cyc; hold = 0; end
    else hold = mem_req;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((stim_q.size() > 0 || reqq.size() > 0 || exp_ready) && n < budget) begin
      step(); n++;
    end
    if (n >= budget) begin
      tests++; fails++;
      $display("FAIL wait_idle: timeout after %0d cycles, %0d queued", budget, reqq.size());
    end
    step();
  endtask

  task automatic push(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_t r;
    r.wr = wr; r.addr = a; r.wdata = d; r.wstrb = s;
    stim_q.push_back(r);
  endtask

  initial begin
    int snap_b, snap_r, snap_w, snap_ar;
    mem_req = 0; mem_wr = 0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; bresp = 0; rresp = 0; rdata = '0;
    p_ready = 100; gap_pct = 0; dly_min = 0; dly_max = 0; aw_late = 0;
    aw_hold = 0; ar_hold = 0; force_resp = 1; spurious = 0;
    f_bresp = 2'b00; f_rresp = 2'b00; f_rdata = '0;
    b_count = 0; ready_count = 0; w_only = 0; ar_seen = 0; last_err = 0;
    model_reset();
    repeat (3) step();
    check("rst_gnt", mem_gnt, 1'b1);
    check("rst_idle", mem_idle, 1'b1);
    rst_n = 1;

    push(1, 32'h100, 32'hDEADBEEF, 4'hF);
    wait_idle(50);
    check("t1_latency", ready_edge - acc_edge, 3);
    check("t1_awaddr", last_awaddr, 32'h100);
    check("t1_wdata", last_wdata, 32'hDEADBEEF);
    check("t1_wstrb", last_wstrb, 4'hF);
    check("t1_err", last_err, 1'b0);

    f_rdata = 32'h12345678; dly_min = 5; dly_max = 5;
    push(0, 32'h200, 32'h0, 4'h0);
    wait_idle(50);
    check("t2_rdata", mem_rdata, 32'h12345678);
    check("t2_err", last_err, 1'b0);
    dly_min = 0; dly_max = 0;

    aw_hold = 1; snap_r = ready_count;
    for (int i = 0; i < 5; i++) push(1, 32'h400 + 4 * i, 32'hA000 + i, 4'hF);
    repeat (12) step();
    check("t3_granted", reqq.size(), 4);
    check("t3_gnt_low", mem_gnt, 1'b0);
    aw_hold = 0;
    wait_idle(100);
    check("t3_pulses", ready_count - snap_r, 5);

    aw_late = 3; snap_b = b_count; snap_w = w_only;
    push(1, 32'h500, 32'h55AA55AA, 4'h3);
    wait_idle(50);
    check("t4_one_b", b_count - snap_b, 1);
    check("t4_aw_alone", w_only - snap_w, 3);
    aw_late = 0;

    f_bresp = 2'b10;
    push(1, 32'h600, 32'h1, 4'h1);
    wait_idle(50);
    check("t5_berr", last_err, 1'b1);
    f_rresp = 2'b11; f_rdata = 32'hCAFEF00D;
    push(0, 32'h604, 32'h0, 4'h0);
    wait_idle(50);
    check("t5_rerr", last_err, 1'b1);
    check("t5_rdata_held", mem_rdata, 32'h12345678);
    f_bresp = 2'b00; f_rresp = 2'b00;

    snap_r = ready_count; spurious = 1;
    repeat (4) step();
    spurious = 0;
    step();
    check("spurious_ignored", ready_count - snap_r, 0);

    ar_hold = 1;
    push(0, 32'h300, 32'h0, 4'h0);
    for (int i = 0; i < 10 && !arvalid; i++) step();
    check("t6_arvalid_up", arvalid, 1'b1);
    @(posedge clk); #2 rst_n = 0; #1;
    check("t6_arvalid", arvalid, 1'b0);
    check("t6_valids", {awvalid, wvalid, bready, rready}, 4'b0);
    check("t6_ready_err", {mem_ready, mem_error}, 2'b00);
    check("t6_rdata", mem_rdata, 32'h0);
    check("t6_gnt_idle", {mem_gnt, mem_idle}, 2'b11);
    model_reset(); ar_hold = 0;
    repeat (2) step();
    rst_n = 1;
    step();

`ifdef DMEM_MISALIGN_CHECK_EN
    snap_ar = ar_seen;
    push(0, 32'h102, 32'h0, 4'h0);
    wait_idle(50);
    check("mis_no_ar", ar_seen - snap_ar, 0);
    check("mis_err", last_err, 1'b1);
    check("mis_latency", ready_edge - acc_edge, 1);
`else
    snap_ar = ar_seen;
    push(0, 32'h102, 32'h0, 4'h0);
    wait_idle(50);
    check("mis_ar_issued", ar_seen - snap_ar, 1);
`endif

    force_resp = 0; p_ready = 70; gap_pct = 30; dly_min = 0; dly_max = 4;
    for (int i = 0; i < 300; i++) push(1'($urandom), $urandom, $urandom, 4'($urandom));
    wait_idle(20000);
    p_ready = 30; gap_pct = 0;
    for (int i = 0; i < 100; i++) push(1'($urandom), $urandom, $urandom, 4'($urandom));
    wait_idle(20000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
